// File: rtl/dmem_arbiter.sv
// Round-robin arbiter that lets CPUS data caches share one word-wide RAM port.
// Optional macro DMEM_BLOCK_LOCK_EN keeps a CPU granted across both words of a dcache block.
module dmem_arbiter #(
    parameter int unsigned CPUS    = 2,
    parameter logic [31:0] ERRWORD = 32'hBAD1BAD1
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic [CPUS-1:0]        dREN,
    input  logic [CPUS-1:0]        dWEN,
    input  logic [CPUS-1:0][31:0]  daddr,
    input  logic [CPUS-1:0][31:0]  dstore,
    output logic [CPUS-1:0]        dwait,
    output logic [CPUS-1:0][31:0]  dload,
    output logic                   ramREN,
    output logic                   ramWEN,
    output logic [31:0]            ramaddr,
    output logic [31:0]            ramstore,
    input  logic [31:0]            ramload,
    input  logic [1:0]             ramstate,
    output logic                   ramerr
);

    localparam int unsigned GW = (CPUS > 1) ? $clog2(CPUS) : 1;
    localparam logic [GW-1:0] LastRst = GW'(CPUS - 1);
    localparam logic [1:0] RamAccess = 2'd2;
    localparam logic [1:0] RamError  = 2'd3;

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e          state_q, state_d;
    logic [GW-1:0]   gnt_q, gnt_d;
    logic [GW-1:0]   last_q, last_d;
    logic            ramerr_q, ramerr_d;
    logic [CPUS-1:0] req;
    logic            found;
    logic            done;
    int unsigned     idx;

`ifdef DMEM_BLOCK_LOCK_EN
    logic            lock_q, lock_d;
    logic [GW-1:0]   lock_cpu_q, lock_cpu_d;
`endif

    assign req    = dREN | dWEN;
    assign ramerr = ramerr_q;
    assign done   = (ramstate == RamAccess) || (ramstate == RamError);

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        last_d   = last_q;
        ramerr_d = ramerr_q;
        dwait    = '1;
        dload    = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        found    = 1'b0;
        idx      = 0;
`ifdef DMEM_BLOCK_LOCK_EN
        lock_d     = lock_q;
        lock_cpu_d = lock_cpu_q;
`endif

        case (state_q)
            StIdle: begin
`ifdef DMEM_BLOCK_LOCK_EN
                // A locked CPU that is still asking gets the second word of its block.
                if (lock_q && req[lock_cpu_q]) begin
                    gnt_d = lock_cpu_q;
                    found = 1'b1;
                end else begin
                    lock_d = 1'b0;
                end
`endif
                for (int unsigned k = 1; k <= CPUS; k++) begin
                    idx = (32'(last_q) + k) % CPUS;
                    if (!found && req[idx]) begin
                        gnt_d = GW'(idx);
                        found = 1'b1;
                    end
                end
                if (|req) begin
                    state_d = StGrant;
                end
            end

            StGrant: begin
                ramaddr  = daddr[gnt_q];
                ramstore = dstore[gnt_q];
                if (!req[gnt_q]) begin
                    // Requester gave up: no completion, round-robin pointer untouched.
                    state_d = StIdle;
                end else begin
                    ramWEN = dWEN[gnt_q];
                    ramREN = dREN[gnt_q] & ~dWEN[gnt_q];
                    if (done) begin
                        dwait[gnt_q] = 1'b0;
                        dload[gnt_q] = (ramstate == RamError) ? ERRWORD : ramload;
                        if (ramstate == RamError) begin
                            ramerr_d = 1'b1;
                        end
                        last_d  = gnt_q;
                        state_d = StIdle;
`ifdef DMEM_BLOCK_LOCK_EN
                        lock_d     = ~daddr[gnt_q][2];
                        lock_cpu_d = gnt_q;
`endif
                    end
                end
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= StIdle;
            gnt_q    <= '0;
            last_q   <= LastRst;
            ramerr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            last_q   <= last_d;
            ramerr_q <= ramerr_d;
        end
    end

`ifdef DMEM_BLOCK_LOCK_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            lock_q     <= 1'b0;
            lock_cpu_q <= '0;
        end else begin
            lock_q     <= lock_d;
            lock_cpu_q <= lock_cpu_d;
        end
    end
`endif

endmodule
